// File: rtl/store_unit.sv
// store_unit: turns a pipeline store request (byte address, right-justified data,
// width code) into word-aligned data-memory writes with per-byte enables.
// Optional feature macro: STORE_MISALIGN_SPLIT_EN
//   defined   - stores crossing a word boundary are issued as two writes (ACC0 then ACC1)
//   undefined - such stores are rejected with st_done + st_err and no memory write
module store_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [2:0]        info_store,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    output logic              st_done,
    output logic              st_err
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc0 = 2'd1,
        StAcc1 = 2'd2
    } state_e;

    localparam logic [2:0] InfoSb = 3'b000;
    localparam logic [2:0] InfoSh = 3'b001;
    localparam logic [2:0] InfoSw = 3'b010;

    state_e              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic                st_done_q, st_done_d;
    logic                st_err_q, st_err_d;
    logic                split_q, split_d;

    logic [1:0]          lane_off;
    logic [7:0]          size_mask;
    logic [7:0]          lane_mask;
    logic                code_bad;
    logic                crosses;
    logic                reject;
    logic [DATA_W-1:0]   wdata_lo;

`ifdef STORE_MISALIGN_SPLIT_EN
    // Second-word payload captured at accept so ACC1 does not depend on st_* inputs.
    logic [DATA_W-1:0]   hi_wdata_q, hi_wdata_d;
    logic [3:0]          hi_be_q, hi_be_d;
    logic [2*DATA_W-1:0] wdata_wide;
`endif

    // Lane math for the incoming request: width mask shifted to the byte offset.
    always_comb begin
        lane_off = st_addr[1:0];
        code_bad = 1'b0;
        unique case (info_store)
            InfoSb:  size_mask = 8'b0000_0001;
            InfoSh:  size_mask = 8'b0000_0011;
            InfoSw:  size_mask = 8'b0000_1111;
            default: begin
                size_mask = 8'b0000_0000;
                code_bad  = 1'b1;
            end
        endcase
        lane_mask = size_mask << lane_off;
        crosses   = |lane_mask[7:4];
        wdata_lo  = st_data << {lane_off, 3'b000};
`ifdef STORE_MISALIGN_SPLIT_EN
        wdata_wide = {{DATA_W{1'b0}}, st_data} << {lane_off, 3'b000};
        reject     = code_bad;
`else
        reject     = code_bad | crosses;
`endif
    end

    assign st_ready  = (state_q == StIdle) && !rst;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign st_done   = st_done_q;
    assign st_err    = st_err_q;

    // Next-state and registered-output computation; everything holds unless changed.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        split_d     = split_q;
        st_done_d   = 1'b0;
        st_err_d    = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
        hi_wdata_d  = hi_wdata_q;
        hi_be_d     = hi_be_q;
`endif
        case (state_q)
            StIdle: begin
                if (st_valid) begin
                    if (reject) begin
                        st_done_d = 1'b1;
                        st_err_d  = 1'b1;
                    end else begin
                        state_d     = StAcc0;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {st_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = lane_mask[3:0];
                        mem_wdata_d = wdata_lo;
                        split_d     = crosses;
`ifdef STORE_MISALIGN_SPLIT_EN
                        hi_wdata_d  = wdata_wide[2*DATA_W-1:DATA_W];
                        hi_be_d     = lane_mask[7:4];
`endif
                    end
                end
            end
            StAcc0: begin
                if (mem_ack) begin
`ifdef STORE_MISALIGN_SPLIT_EN
                    if (split_q) begin
                        // Address wraps naturally at the top of the address space.
                        state_d     = StAcc1;
                        mem_addr_d  = mem_addr_q + ADDR_W'(4);
                        mem_be_d    = hi_be_q;
                        mem_wdata_d = hi_wdata_q;
                    end else begin
                        state_d   = StIdle;
                        mem_req_d = 1'b0;
                        st_done_d = 1'b1;
                    end
`else
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    st_done_d = 1'b1;
`endif
                end
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            StAcc1: begin
                if (mem_ack) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    st_done_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronous reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
            st_done_q   <= 1'b0;
            st_err_q    <= 1'b0;
            split_q     <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
            hi_wdata_q  <= '0;
            hi_be_q     <= 4'b0000;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            st_done_q   <= st_done_d;
            st_err_q    <= st_err_d;
            split_q     <= split_d;
`ifdef STORE_MISALIGN_SPLIT_EN
            hi_wdata_q  <= hi_wdata_d;
            hi_be_q     <= hi_be_d;
`endif
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed plus randomized store requests checked against a
// byte-level reference model (each stored byte lands in word addr&~3, lane addr&3).
module tb_store_unit;

`ifdef STORE_MISALIGN_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  info_store;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        st_done;
    logic        st_err;

    int checks = 0;
    int failures = 0;

    store_unit dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .info_store(info_store),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .st_done   (st_done),
        .st_err    (st_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Reference model: walk the stored bytes one by one and group them into words.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] info,
                         output int n, output bit rej,
                         output logic [31:0] wa [2], output logic [3:0] wbe [2],
                         output logic [31:0] wd [2]);
        int sz;
        logic [31:0] ba;
        logic [31:0] word;
        int idx;
        case (info)
            3'b000:  sz = 1;
            3'b001:  sz = 2;
            3'b010:  sz = 4;
            default: sz = 0;
        endcase
        n = 0;
        for (int w = 0; w < 2; w++) begin
            wa[w] = '0; wbe[w] = '0; wd[w] = '0;
        end
        for (int k = 0; k < sz; k++) begin
            ba   = a + 32'(k);
            word = ba & 32'hFFFF_FFFC;
            if (n == 0 || word != wa[n-1]) begin
                wa[n] = word;
                n++;
            end
            idx = n - 1;
            wbe[idx][ba[1:0]] = 1'b1;
            wd[idx][8*ba[1:0] +: 8] = d[8*k +: 8];
        end
        rej = (sz == 0) || (n > 1 && !SplitEn);
    endtask

    // Issue one request starting at a negedge in IDLE; ends at the negedge showing st_done.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] info,
                            input int dly);
        int n;
        bit rej;
        logic [31:0] wa [2];
        logic [3:0]  wbe [2];
        logic [31:0] wd [2];
        model(a, d, info, n, rej, wa, wbe, wd);
        chk("st_ready_idle", st_ready, 1);
        st_valid   = 1'b1;
        st_addr    = a;
        st_data    = d;
        info_store = info;
        @(posedge clk);
        @(negedge clk);
        st_valid   = 1'b0;
        st_addr    = $urandom;
        st_data    = $urandom;
        info_store = 3'($urandom);
        if (rej) begin
            chk("rej_mem_req", mem_req, 0);
            chk("rej_st_done", st_done, 1);
            chk("rej_st_err", st_err, 1);
            return;
        end
        for (int w = 0; w < n; w++) begin
            for (int c = 0; c <= dly; c++) begin
                chk("mem_req", mem_req, 1);
                chk("mem_addr", mem_addr, wa[w]);
                chk("mem_be", mem_be, wbe[w]);
                chk("mem_wdata", mem_wdata & lane_mask(wbe[w]), wd[w]);
                chk("st_done_busy", st_done, 0);
                if (c == dly) mem_ack = 1'b1;
                @(posedge clk);
                @(negedge clk);
            end
            mem_ack = 1'b0;
        end
        chk("end_mem_req", mem_req, 0);
        chk("end_st_done", st_done, 1);
        chk("end_st_err", st_err, 0);
    endtask

    initial begin
        logic [2:0] code;
        rst        = 1'b1;
        st_valid   = 1'b0;
        st_addr    = '0;
        st_data    = '0;
        info_store = '0;
        mem_ack    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_st_done", st_done, 0);
        chk("rst_st_err", st_err, 0);
        chk("rst_st_ready", st_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", st_ready, 1);
        @(negedge clk);

        // Directed steps
        do_store(32'h0000_1002, 32'h0000_00AB, 3'b000, 0);
        do_store(32'h0000_2001, 32'h0000_BEEF, 3'b001, 3);
        do_store(32'h0000_3003, 32'h1122_3344, 3'b010, 1);
        do_store(32'hFFFF_FFFE, 32'hCAFE_F00D, 3'b010, 0);
        do_store(32'h0000_0040, 32'h5566_7788, 3'b111, 0);
        do_store(32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 0);

        // Reset while ACC0 holds mem_req
        chk("pre_rst_ready", st_ready, 1);
        st_valid = 1'b1; st_addr = 32'h0000_0020; st_data = 32'h0102_0304; info_store = 3'b010;
        @(posedge clk);
        @(negedge clk);
        st_valid = 1'b0;
        chk("acc0_mem_req", mem_req, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_st_done", st_done, 0);
        rst = 1'b0;
        #1;
        chk("midrst_ready", st_ready, 1);
        @(negedge clk);
        chk("midrst_no_done", st_done, 0);
        chk("midrst_idle_req", mem_req, 0);

        // Ack while idle must be ignored
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack_req", mem_req, 0);
        chk("stray_ack_done", st_done, 0);

        // Randomized back-to-back requests
        for (int i = 0; i < 60; i++) begin
            code = 3'($urandom_range(0, 3));
            if (code == 3'd3) code = 3'($urandom_range(3, 7));
            do_store($urandom, $urandom, code, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
